// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: registers execute results, resolves conditional branches,
// runs the data-memory request/ready handshake and emits one write-back beat per instruction.
module ex_mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_ALUResult,
  input  logic [31:0] i_PCBranch,
  input  logic        i_zero,
  input  logic        i_negative,
  input  logic [31:0] i_register2,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_Branch,
  input  logic [1:0]  i_BranchType,
  input  logic        i_RegWrite,
  input  logic [4:0]  i_rd,
  output logic        o_stall,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_PCSrc,
  output logic [31:0] o_PCBranch_q,
  output logic        o_wb_valid,
  output logic        o_wb_RegWrite,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_result,
  output logic        o_mem_err
);

  typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [31:0]       addr_reg, wdata_reg;
  logic [4:0]        rd_reg;
  logic              reg_write_reg, mem_read_reg, mem_write_reg;
  logic              accept, mem_instr, complete, abort, cond;

  assign accept    = i_valid && (state_reg == IDLE);
  assign mem_instr = i_MemRead | i_MemWrite;
  assign complete  = (state_reg == MEM) && i_mem_ready;
  // Ready on the timeout edge wins, so abort requires ready low.
  assign abort     = (TIMEOUT > 0) && (state_reg == MEM) && !i_mem_ready && (cnt_reg == CNT_LAST);

  always_comb begin
    cond = 1'b0;
    case (i_BranchType)
      2'b00: cond = i_zero;
      2'b01: cond = !i_zero;
      2'b10: cond = i_negative;
      2'b11: cond = !i_negative;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && mem_instr) state_next = MEM;
      MEM:  if (complete || abort)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_stall     = (state_reg == MEM);
    o_mem_req   = (state_reg == MEM);
    o_mem_we    = (state_reg == MEM) && mem_write_reg;
    o_mem_addr  = (state_reg == MEM) ? addr_reg  : 32'd0;
    o_mem_wdata = (state_reg == MEM) ? wdata_reg : 32'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg       <= '0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      rd_reg        <= 5'd0;
      reg_write_reg <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      o_PCSrc       <= 1'b0;
      o_PCBranch_q  <= 32'd0;
      o_wb_valid    <= 1'b0;
      o_wb_RegWrite <= 1'b0;
      o_wb_rd       <= 5'd0;
      o_wb_result   <= 32'd0;
      o_mem_err     <= 1'b0;
    end else begin
      o_PCSrc    <= accept && i_Branch && cond;
      o_wb_valid <= 1'b0;
      o_mem_err  <= 1'b0;

      if (accept) begin
        cnt_reg       <= '0;
        addr_reg      <= i_ALUResult;
        wdata_reg     <= i_register2;
        rd_reg        <= i_rd;
        reg_write_reg <= i_RegWrite;
        mem_read_reg  <= i_MemRead;
        mem_write_reg <= i_MemWrite;
        o_PCBranch_q  <= i_PCBranch;
        if (!mem_instr) begin
          o_wb_valid    <= 1'b1;
          o_wb_RegWrite <= i_RegWrite;
          o_wb_rd       <= i_rd;
          o_wb_result   <= i_ALUResult;
        end
      end else if ((state_reg == MEM) && !i_mem_ready) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (complete) begin
        o_wb_valid    <= 1'b1;
        o_wb_RegWrite <= reg_write_reg;
        o_wb_rd       <= rd_reg;
        // MemWrite wins when both flags are set, so only a pure load returns memory data.
        o_wb_result   <= (mem_read_reg && !mem_write_reg) ? i_mem_rdata : addr_reg;
      end else if (abort) begin
        o_wb_valid    <= 1'b1;
        o_mem_err     <= 1'b1;
        o_wb_RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a timeline model schedules expected outputs per cycle when each
// instruction is accepted; a negedge process compares every cycle, plus literal directed checks.
module tb_ex_mem_stage;

  localparam int TO   = 4;
  localparam int MAXC = 4000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid;
  logic [31:0] i_ALUResult, i_PCBranch, i_register2, i_mem_rdata;
  logic        i_zero, i_negative, i_MemRead, i_MemWrite, i_Branch, i_RegWrite, i_mem_ready;
  logic [1:0]  i_BranchType;
  logic [4:0]  i_rd;
  logic        o_stall, o_mem_req, o_mem_we, o_PCSrc, o_wb_valid, o_wb_RegWrite, o_mem_err;
  logic [31:0] o_mem_addr, o_mem_wdata, o_PCBranch_q, o_wb_result;
  logic [4:0]  o_wb_rd;

  ex_mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_ALUResult(i_ALUResult), .i_PCBranch(i_PCBranch), .i_zero(i_zero),
    .i_negative(i_negative), .i_register2(i_register2), .i_MemRead(i_MemRead),
    .i_MemWrite(i_MemWrite), .i_Branch(i_Branch), .i_BranchType(i_BranchType),
    .i_RegWrite(i_RegWrite), .i_rd(i_rd), .o_stall(o_stall), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata), .o_PCSrc(o_PCSrc),
    .o_PCBranch_q(o_PCBranch_q), .o_wb_valid(o_wb_valid), .o_wb_RegWrite(o_wb_RegWrite),
    .o_wb_rd(o_wb_rd), .o_wb_result(o_wb_result), .o_mem_err(o_mem_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] alu, pcb, r2, rdata;
    logic        z, n, mr, mw, br, rw;
    logic [1:0]  bt;
    logic [4:0]  rd;
    logic [3:0]  d;      // MEM cycles before ready; >= TO means ready never comes
  } instr_t;

  // Expected value of each output during cycle k (the interval after rising edge k).
  logic        exp_stall[MAXC], exp_pcsrc[MAXC], exp_wbv[MAXC], exp_err[MAXC];
  logic        exp_rw[MAXC], exp_we[MAXC], plan_ready[MAXC];
  logic [31:0] exp_pcq[MAXC], exp_res[MAXC], exp_addr[MAXC], exp_wdata[MAXC], plan_rdata[MAXC];
  logic [4:0]  exp_rd[MAXC];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int txn = 0;
  logic chk_on = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
    end
  endtask

  task automatic clear_from(input int c);
    for (int k = c; k < MAXC; k++) begin
      exp_stall[k] = 0; exp_pcsrc[k] = 0; exp_wbv[k] = 0; exp_err[k] = 0;
      exp_rw[k] = 0; exp_we[k] = 0; plan_ready[k] = 0;
      exp_pcq[k] = 0; exp_res[k] = 0; exp_addr[k] = 0; exp_wdata[k] = 0;
      plan_rdata[k] = 0; exp_rd[k] = 0;
    end
  endtask

  // Record the expected timeline of one instruction accepted at edge n.
  task automatic schedule(input instr_t t, input int n);
    logic taken;
    int e;
    case (t.bt)
      2'b00: taken = t.z;
      2'b01: taken = !t.z;
      2'b10: taken = t.n;
      default: taken = !t.n;
    endcase
    exp_pcsrc[n] = t.br & taken;
    for (int k = n; k < MAXC; k++) exp_pcq[k] = t.pcb;
    if (t.mr || t.mw) begin
      e = (int'(t.d) < TO) ? n + 1 + int'(t.d) : n + TO;
      for (int k = n; k < e; k++) begin
        exp_stall[k] = 1; exp_we[k] = t.mw; exp_addr[k] = t.alu; exp_wdata[k] = t.r2;
      end
      exp_wbv[e] = 1;
      if (int'(t.d) < TO) begin
        plan_ready[n + int'(t.d)] = 1;
        plan_rdata[n + int'(t.d)] = t.rdata;
        for (int k = e; k < MAXC; k++) begin
          exp_rw[k] = t.rw; exp_rd[k] = t.rd;
          exp_res[k] = (t.mr && !t.mw) ? t.rdata : t.alu;
        end
      end else begin
        exp_err[e] = 1;
        for (int k = e; k < MAXC; k++) exp_rw[k] = 0;
      end
    end else begin
      exp_wbv[n] = 1;
      for (int k = n; k < MAXC; k++) begin
        exp_rw[k] = t.rw; exp_rd[k] = t.rd; exp_res[k] = t.alu;
      end
    end
  endtask

  task automatic set_mem_inputs();
    if (exp_stall[cyc] && plan_ready[cyc]) begin
      i_mem_ready = 1'b1; i_mem_rdata = plan_rdata[cyc];
    end else if (exp_stall[cyc]) begin
      i_mem_ready = 1'b0; i_mem_rdata = $urandom;
    end else begin
      i_mem_ready = 1'($urandom); i_mem_rdata = $urandom;   // ignored while idle
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    if (cyc >= MAXC - 8) begin
      $display("FAIL cycle_budget cyc=%0d got=overrun want=<%0d", cyc, MAXC - 8);
      $fatal(1, "cycle budget exhausted");
    end
    set_mem_inputs();
  endtask

  task automatic drive(input instr_t t, input logic v);
    i_valid = v; i_ALUResult = t.alu; i_PCBranch = t.pcb; i_register2 = t.r2;
    i_zero = t.z; i_negative = t.n; i_MemRead = t.mr; i_MemWrite = t.mw;
    i_Branch = t.br; i_BranchType = t.bt; i_RegWrite = t.rw; i_rd = t.rd;
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    t.alu = $urandom; t.pcb = $urandom; t.r2 = $urandom; t.rdata = $urandom;
    t.z = 1'($urandom); t.n = 1'($urandom); t.br = 1'($urandom); t.rw = 1'($urandom);
    t.bt = 2'($urandom); t.rd = 5'($urandom);
    k = $urandom_range(0, 9);
    t.mr = ((k >= 4) && (k <= 6)) || (k == 9);
    t.mw = (k >= 7);
    t.d = 4'($urandom_range(0, 5));
    return t;
  endfunction

  function automatic instr_t base();
    instr_t t;
    t = '0;
    return t;
  endfunction

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      drive(rand_instr(), 1'b0);
      step();
    end
  endtask

  // Present t with i_valid held through any stall; returns with the clock just past acceptance.
  task automatic issue(input instr_t t);
    int n;
    while (exp_stall[cyc]) begin
      drive(t, 1'b1);
      step();
    end
    drive(t, 1'b1);
    n = cyc + 1;
    schedule(t, n);
    txn++;
    $display("TXN %0d edge=%0d alu=%h rd=%0d mr=%0b mw=%0b br=%0b bt=%0d d=%0d",
             txn, n, t.alu, t.rd, t.mr, t.mw, t.br, t.bt, t.d);
    step();
    drive(rand_instr(), 1'b0);
  endtask

  always @(negedge i_clk) begin
    if (chk_on) begin
      chk("stall", 32'(o_stall), 32'(exp_stall[cyc]));
      chk("mem_req", 32'(o_mem_req), 32'(exp_stall[cyc]));
      chk("pcsrc", 32'(o_PCSrc), 32'(exp_pcsrc[cyc]));
      chk("pcbranch_q", o_PCBranch_q, exp_pcq[cyc]);
      chk("wb_valid", 32'(o_wb_valid), 32'(exp_wbv[cyc]));
      chk("mem_err", 32'(o_mem_err), 32'(exp_err[cyc]));
      chk("wb_regwrite", 32'(o_wb_RegWrite), 32'(exp_rw[cyc]));
      chk("wb_rd", 32'(o_wb_rd), 32'(exp_rd[cyc]));
      chk("wb_result", o_wb_result, exp_res[cyc]);
      if (exp_stall[cyc]) begin
        chk("mem_we", 32'(o_mem_we), 32'(exp_we[cyc]));
        chk("mem_addr", o_mem_addr, exp_addr[cyc]);
        chk("mem_wdata", o_mem_wdata, exp_wdata[cyc]);
      end
    end
  end

  initial begin
    instr_t t;
    int cnt;
    clear_from(0);
    drive(base(), 1'b0);
    i_mem_ready = 1'b0;
    i_mem_rdata = 32'd0;
    chk_on = 1'b1;

    #12;
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_pcsrc", 32'(o_PCSrc), 32'd0);
    chk("rst_pcbranch_q", o_PCBranch_q, 32'd0);
    chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("rst_wb_result", o_wb_result, 32'd0);
    chk("rst_mem_err", 32'(o_mem_err), 32'd0);
    #10 i_rst_n = 1'b1;
    step();

    // ADD x5 = 0x10
    t = base(); t.alu = 32'h10; t.rw = 1; t.rd = 5'd5;
    issue(t);
    chk("add_wb_valid", 32'(o_wb_valid), 32'd1);
    chk("add_wb_rd", 32'(o_wb_rd), 32'd5);
    chk("add_wb_result", o_wb_result, 32'h10);
    chk("add_stall", 32'(o_stall), 32'd0);
    step();
    chk("add_wb_pulse_end", 32'(o_wb_valid), 32'd0);

    // BEQ taken, then BLT not taken
    t = base(); t.br = 1; t.bt = 2'b00; t.z = 1; t.pcb = 32'h40;
    issue(t);
    chk("beq_pcsrc", 32'(o_PCSrc), 32'd1);
    chk("beq_pcbranch_q", o_PCBranch_q, 32'h40);
    t = base(); t.br = 1; t.bt = 2'b10; t.n = 0; t.pcb = 32'h80;
    issue(t);
    chk("blt_pcsrc", 32'(o_PCSrc), 32'd0);

    // Load 0x100, ready three cycles after the request
    idle(1);
    t = base(); t.mr = 1; t.rw = 1; t.rd = 5'd3; t.alu = 32'h100; t.d = 4'd3;
    t.rdata = 32'hDEAD_BEEF;
    issue(t);
    chk("load_addr", o_mem_addr, 32'h100);
    chk("load_we", 32'(o_mem_we), 32'd0);
    cnt = 0;
    while (o_stall && cnt < 20) begin
      cnt++;
      step();
    end
    chk("load_stall_cycles", 32'(cnt), 32'd4);
    chk("load_wb_valid", 32'(o_wb_valid), 32'd1);
    chk("load_wb_result", o_wb_result, 32'hDEAD_BEEF);

    // Load followed by an instruction held valid during the stall
    t = base(); t.mr = 1; t.rw = 1; t.rd = 5'd4; t.alu = 32'h104; t.d = 4'd1; t.rdata = 32'h5A5A_0001;
    issue(t);
    t = base(); t.rw = 1; t.rd = 5'd7; t.alu = 32'h55;
    issue(t);
    chk("held_wb_rd", 32'(o_wb_rd), 32'd7);

    // Store ready in the first MEM cycle
    t = base(); t.mw = 1; t.alu = 32'h200; t.r2 = 32'h1234_5678; t.d = 4'd0;
    issue(t);
    chk("store_we", 32'(o_mem_we), 32'd1);
    chk("store_addr", o_mem_addr, 32'h200);
    chk("store_wdata", o_mem_wdata, 32'h1234_5678);
    step();
    chk("store_req_drop", 32'(o_mem_req), 32'd0);
    chk("store_wb_valid", 32'(o_wb_valid), 32'd1);
    chk("store_wb_result", o_wb_result, 32'h200);

    // Load that never gets ready: timeout abort
    t = base(); t.mr = 1; t.rw = 1; t.rd = 5'd9; t.alu = 32'h300; t.d = 4'd15;
    issue(t);
    cnt = 0;
    while (o_mem_req && cnt < 20) begin
      cnt++;
      step();
    end
    chk("timeout_req_cycles", 32'(cnt), 32'd4);
    chk("timeout_err", 32'(o_mem_err), 32'd1);
    chk("timeout_wb_valid", 32'(o_wb_valid), 32'd1);
    chk("timeout_regwrite", 32'(o_wb_RegWrite), 32'd0);
    chk("timeout_idle", 32'(o_stall), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 250; i++) begin
      issue(rand_instr());
      idle($urandom_range(0, 2));
    end

    // Reset in the middle of an outstanding access
    idle(1);
    t = base(); t.mr = 1; t.rw = 1; t.rd = 5'd2; t.alu = 32'h400; t.d = 4'd15;
    issue(t);
    step();
    #1;
    i_rst_n = 1'b0;
    clear_from(cyc);
    #1;
    chk("arst_mem_req", 32'(o_mem_req), 32'd0);
    chk("arst_stall", 32'(o_stall), 32'd0);
    step();
    step();
    #2 i_rst_n = 1'b1;
    idle(1);
    t = base(); t.rw = 1; t.rd = 5'd9; t.alu = 32'h77;
    issue(t);
    chk("post_rst_wb_valid", 32'(o_wb_valid), 32'd1);
    chk("post_rst_wb_rd", 32'(o_wb_rd), 32'd9);
    chk("post_rst_wb_result", o_wb_result, 32'h77);
    idle(3);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Consumer end of the execute-stage result interface: registers EX outputs (ALU result, branch target, zero/negative flags, store data, control) into the EX/MEM boundary.
- Resolves conditional branches and drives the data-memory request/ready handshake.
- Stalls upstream while an access is outstanding, then presents one write-back beat per instruction.
- Sits between the EX stage and the WB stage of the RISC-V pipeline.

Parameters:
- TIMEOUT, 16, maximum cycles a memory request stays pending before abort; 0 disables timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  EX presents an instruction this cycle.
- i_ALUResult  input  32  ALU result; memory address for loads/stores.
- i_PCBranch  input  32  branch target.
- i_zero  input  1  ALU zero flag.
- i_negative  input  1  ALU negative flag.
- i_register2  input  32  store data.
- i_MemRead  input  1  load.
- i_MemWrite  input  1  store.
- i_Branch  input  1  conditional branch.
- i_BranchType  input  2  00 BEQ, 01 BNE, 10 BLT, 11 BGE.
- i_RegWrite  input  1  instruction writes rd.
- i_rd  input  5  destination register.
- o_stall  output  1  upstream must hold; i_valid ignored while high.
- o_mem_req  output  1  memory request.
- o_mem_we  output  1  1 = write.
- o_mem_addr  output  32  address.
- o_mem_wdata  output  32  write data.
- i_mem_ready  input  1  memory accepts/completes the request this cycle.
- i_mem_rdata  input  32  load data, valid when i_mem_ready = 1.
- o_PCSrc  output  1  one-cycle pulse: branch taken.
- o_PCBranch_q  output  32  registered branch target.
- o_wb_valid  output  1  one-cycle write-back beat.
- o_wb_RegWrite  output  1  write enable for WB.
- o_wb_rd  output  5  destination register.
- o_wb_result  output  32  load data, or ALU result for non-loads.
- o_mem_err  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async, i_rst_n = 0): state IDLE; every output 0, including o_PCBranch_q, o_wb_result and the wait counter. Reset asserted during MEM drops o_mem_req immediately; the pending access is discarded.
- FSM has two states, IDLE and MEM. o_stall = (state == MEM).
- Acceptance happens at any rising edge with i_valid = 1 and o_stall = 0. On acceptance:
  - Latch rd, RegWrite, ALUResult, register2, and the mem flags.
  - o_PCBranch_q <= i_PCBranch.
  - o_PCSrc <= i_Branch & cond, where cond = zero (BEQ), !zero (BNE), negative (BLT), !negative (BGE).
  - o_PCSrc is high for exactly one cycle. Branch evaluation is independent of the mem flags.
- Non-memory instruction accepted at edge N: o_wb_valid = 1 during cycle N+1 only. o_wb_result = ALUResult; o_wb_RegWrite = RegWrite; state stays IDLE, so back-to-back acceptance is allowed.
- Memory instruction (MemRead | MemWrite) accepted at edge N:
  - State -> MEM from cycle N+1.
  - o_mem_req = 1; o_mem_addr = ALUResult; o_mem_we = MemWrite (MemWrite wins if both flags are set); o_mem_wdata = register2.
  - These outputs hold stable until completion.
- Completion at the first edge M in MEM with i_mem_ready = 1:
  - o_wb_valid = 1 in cycle M+1.
  - o_wb_result = i_mem_rdata for a load, ALUResult for a store.
  - State -> IDLE; o_mem_req = 0 in cycle M+1.
  - o_stall is high through cycle M, so the next instruction is accepted at edge M+1 at the earliest.
- Wait counter: cleared on entry to MEM, increments each MEM cycle without ready.
- Timeout (TIMEOUT > 0): if the counter reaches TIMEOUT-1 and i_mem_ready = 0 at that edge, abort.
  - o_mem_err and o_wb_valid pulse one cycle; o_wb_RegWrite forced to 0.
  - State -> IDLE. i_mem_ready sampled on the same edge as the timeout takes priority, giving a normal completion.
- i_mem_ready while IDLE is ignored.
- When not pulsing, o_wb_valid, o_PCSrc and o_mem_err are 0. o_wb_* data fields hold their last values.

Test Plan:
- Reset, then ADD (RegWrite = 1, rd = 5, ALUResult = 0x0000_0010) at edge 1 -> o_wb_valid = 1, rd = 5, result = 0x10 in cycle 2 only; o_stall stays 0.
- BEQ with zero = 1, PCBranch = 0x0000_0040 -> o_PCSrc = 1 one cycle, o_PCBranch_q = 0x40. BLT with negative = 0 -> o_PCSrc stays 0.
- Load at addr 0x100, i_mem_ready high 3 cycles after req, rdata = 0xDEAD_BEEF -> o_stall high 3 cycles plus the ready cycle. Then o_wb_valid with result 0xDEADBEEF; a second i_valid held during the stall is accepted on the edge after ready.
- Store addr 0x200, wdata 0x1234_5678, ready in first MEM cycle -> o_mem_we = 1 for one cycle, addr/wdata correct; o_wb_valid next cycle with result 0x200.
- Load with TIMEOUT = 4, ready never asserted -> o_mem_req high for 4 cycles. Then o_mem_err = 1 and o_wb_valid = 1 with RegWrite = 0; state IDLE.
- Assert i_rst_n = 0 mid-MEM -> o_mem_req and o_stall drop asynchronously. After release, a fresh ADD completes normally.
